// File: rtl/pen_servo_pkg.sv
// Shared definitions for the pen servo sequencer: state encoding,
// default timing constants and the ms-to-cycles conversion helper.
package pen_servo_pkg;

  // Sequencer states, 2-bit encoding fixed so the state can be probed externally
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // 100 MHz system clock
  localparam int unsigned DEFAULT_CYCLES_PER_MS = 100000;

  // Servo travel time allowed after the pen changes position
  localparam int unsigned DEFAULT_SETTLE_MS = 300;

  // Convert a millisecond count into clock cycles at full 32-bit width.
  // 255 ms at 100000 cycles/ms is 25,500,000, well inside 32 bits.
  function automatic logic [31:0] ms_to_cycles(input logic [31:0] ms,
                                               input logic [31:0] cycles_per_ms);
    return ms * cycles_per_ms;
  endfunction

endpackage

// File: rtl/pen_servo_seq_cycle_timer.sv
// Loadable 32-bit down-counter used to time the MOVE and HOLD intervals.
// The counter is loaded with (interval - 1) on state entry, so expired is
// high during the final cycle of the interval and the FSM leaves the state
// on the edge that ends that cycle.
module cycle_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] value,
  output logic        expired
);

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 32'd0;
    end else if (load) begin
      value <= load_value;
    end else if (value != 32'd0) begin
      value <= value - 32'd1;
    end
  end

  assign expired = (value == 32'd0);

endmodule

// File: rtl/pen_servo_seq.sv
// Pen servo sequencer: accepts a pen up/down command, drives the registered
// pen level, waits for the servo to travel (only when the level actually
// changes), dwells for the commanded hold time and then pulses done.
module pen_servo_seq
  import pen_servo_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = DEFAULT_CYCLES_PER_MS,
  parameter int unsigned SETTLE_MS     = DEFAULT_SETTLE_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_down,
  input  logic [7:0] cmd_hold_ms,
  output logic       cmd_ready,
  output logic       write,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] CPM           = 32'(CYCLES_PER_MS);
  localparam logic [31:0] SETTLE_CYCLES = ms_to_cycles(32'(SETTLE_MS), CPM);

  state_t      state;
  logic [7:0]  hold_ms;
  logic [31:0] cmd_hold_cycles;
  logic [31:0] held_hold_cycles;
  logic        need_move;

  logic        timer_load;
  logic [31:0] timer_load_value;
  logic [31:0] timer_value;
  logic        timer_expired;
  logic        unused_timer_value;

  // The FSM only needs the expired flag; the raw count is kept on the port for probing
  assign unused_timer_value = ^timer_value;

  assign cmd_hold_cycles  = ms_to_cycles({24'd0, cmd_hold_ms}, CPM);
  assign held_hold_cycles = ms_to_cycles({24'd0, hold_ms}, CPM);

  // A travel interval is only needed when the new level differs from the current one
  assign need_move = (cmd_down != write) && (SETTLE_CYCLES != 32'd0);

  // Status outputs are decoded purely from the registered state
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Decide when the interval timer is (re)loaded and with which length
  always_comb begin
    timer_load       = 1'b0;
    timer_load_value = 32'd0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (need_move) begin
            timer_load       = 1'b1;
            timer_load_value = SETTLE_CYCLES - 32'd1;
          end else if (cmd_hold_cycles != 32'd0) begin
            timer_load       = 1'b1;
            timer_load_value = cmd_hold_cycles - 32'd1;
          end
        end
      end
      MOVE: begin
        if (timer_expired && (held_hold_cycles != 32'd0)) begin
          timer_load       = 1'b1;
          timer_load_value = held_hold_cycles - 32'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Sequencer FSM with the registered pen level; reset always wins over a command
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      write   <= 1'b0;
      hold_ms <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write   <= cmd_down;
            hold_ms <= cmd_hold_ms;
            if (need_move) begin
              state <= MOVE;
            end else if (cmd_hold_cycles != 32'd0) begin
              state <= HOLD;
            end else begin
              state <= DONE;
            end
          end
        end
        MOVE: begin
          if (timer_expired) begin
            state <= (held_hold_cycles != 32'd0) ? HOLD : DONE;
          end
        end
        HOLD: begin
          if (timer_expired) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  cycle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expired    (timer_expired)
  );

endmodule
